// File: rtl/axil_cmd_master_if.sv
// AXI-Lite master/slave channel bundle between axil_cmd_master and the register map.
interface axil_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Converts a valid/ready command stream into single AXI-Lite transactions,
// one outstanding at a time, and returns each completion on a response stream.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W offered; each drops independently after its handshake
// WR_RESP | bready high, waiting for the write response
// RD_REQ  | AR offered until accepted
// RD_DATA | rready high, waiting for read data
// RSP     | response held on the rsp stream until rsp_ready
module axil_cmd_master #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                    clk,
  input  logic                    rstn,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,

  axil_cmd_master_if.master       cbus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;
  logic                  aw_done;
  logic                  w_done;

  logic                  awvalid_c;
  logic                  wvalid_c;
  logic                  bready_c;
  logic                  arvalid_c;
  logic                  rready_c;
  logic                  cmd_ready_c;
  logic                  rsp_valid_c;

  logic                  cmd_fire;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  b_fire;
  logic                  r_fire;

  assign cmd_fire = cmd_valid && cmd_ready_c;
  assign aw_fire  = awvalid_c && cbus.awready;
  assign w_fire   = wvalid_c && cbus.wready;
  assign b_fire   = bready_c && cbus.bvalid;
  assign r_fire   = rready_c && cbus.rvalid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Valids are decoded from the registered state so reset drops them at once.
  always_comb begin
    state_nxt   = state;
    cmd_ready_c = 1'b0;
    awvalid_c   = 1'b0;
    wvalid_c    = 1'b0;
    bready_c    = 1'b0;
    arvalid_c   = 1'b0;
    rready_c    = 1'b0;
    rsp_valid_c = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (cmd_valid) begin
          state_nxt = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        awvalid_c = !aw_done;
        wvalid_c  = !w_done;
        if ((aw_done || (!aw_done && cbus.awready)) &&
            (w_done  || (!w_done  && cbus.wready))) begin
          state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        bready_c = 1'b1;
        if (cbus.bvalid) begin
          state_nxt = RSP;
        end
      end
      RD_REQ: begin
        arvalid_c = 1'b1;
        if (cbus.arready) begin
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        rready_c = 1'b1;
        if (cbus.rvalid) begin
          state_nxt = RSP;
        end
      end
      RSP: begin
        rsp_valid_c = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      resp_q  <= 2'b00;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        write_q <= cmd_write;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_fire) begin
        aw_done <= 1'b1;
      end
      if (w_fire) begin
        w_done <= 1'b1;
      end
      if (b_fire) begin
        resp_q  <= cbus.bresp;
        rdata_q <= '0;
      end
      if (r_fire) begin
        resp_q  <= cbus.rresp;
        rdata_q <= cbus.rdata;
      end
    end
  end

  assign cmd_ready    = cmd_ready_c;
  assign rsp_valid    = rsp_valid_c;
  assign rsp_write    = write_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_resp     = resp_q;

  assign cbus.awaddr  = addr_q;
  assign cbus.awprot  = PROT;
  assign cbus.awvalid = awvalid_c;
  assign cbus.wdata   = wdata_q;
  assign cbus.wstrb   = wstrb_q;
  assign cbus.wvalid  = wvalid_c;
  assign cbus.bready  = bready_c;
  assign cbus.araddr  = addr_q;
  assign cbus.arprot  = PROT;
  assign cbus.arvalid = arvalid_c;
  assign cbus.rready  = rready_c;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master against a small masked-register slave model.
module tb_axil_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [31:0]   cmd_addr  = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_write;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;

  axil_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cbus ();

  axil_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT(3'b000)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .cbus      (cbus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slave model: 16 word registers indexed by addr[3:0], each with a writable-bit mask.
  int          aw_delay = 0;
  int          w_delay  = 0;
  logic        b_hold   = 1'b0;
  logic [1:0]  bresp_val = 2'b00;
  logic [1:0]  rresp_val = 2'b00;

  int          aw_cnt;
  int          w_cnt;
  logic        aw_got;
  logic        w_got;
  logic [3:0]  aw_idx;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [31:0] mem [16];

  logic        aw_hs, w_hs, aw_now, w_now;
  logic [3:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  function automatic logic [31:0] reg_mask(input logic [3:0] i);
    case (i)
      4'd1:    return 32'h0000_00FF;
      4'd2:    return 32'h0000_FFFF;
      4'd3:    return 32'h0000_0F0F;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  assign cbus.awready = cbus.awvalid && (aw_cnt >= aw_delay);
  assign cbus.wready  = cbus.wvalid && (w_cnt >= w_delay);
  assign cbus.arready = cbus.arvalid;
  assign aw_hs   = cbus.awvalid && cbus.awready;
  assign w_hs    = cbus.wvalid && cbus.wready;
  assign aw_now  = aw_got || aw_hs;
  assign w_now   = w_got || w_hs;
  assign wr_idx  = aw_hs ? cbus.awaddr[3:0] : aw_idx;
  assign wr_data = w_hs ? cbus.wdata : w_data_q;
  assign wr_strb = w_hs ? cbus.wstrb : w_strb_q;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_cnt      <= 0;
      w_cnt       <= 0;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      aw_idx      <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      cbus.bvalid <= 1'b0;
      cbus.bresp  <= 2'b00;
      cbus.rvalid <= 1'b0;
      cbus.rdata  <= '0;
      cbus.rresp  <= 2'b00;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      aw_cnt <= (cbus.awvalid && !cbus.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (cbus.wvalid && !cbus.wready) ? w_cnt + 1 : 0;
      if (aw_hs) begin
        aw_got <= 1'b1;
        aw_idx <= cbus.awaddr[3:0];
      end
      if (w_hs) begin
        w_got    <= 1'b1;
        w_data_q <= cbus.wdata;
        w_strb_q <= cbus.wstrb;
      end
      if (cbus.bvalid && cbus.bready) begin
        cbus.bvalid <= 1'b0;
      end else if (aw_now && w_now && !cbus.bvalid && !b_hold) begin
        mem[wr_idx] <= merge(mem[wr_idx], wr_data, wr_strb) & reg_mask(wr_idx);
        cbus.bvalid <= 1'b1;
        cbus.bresp  <= bresp_val;
        aw_got      <= 1'b0;
        w_got       <= 1'b0;
      end
      if (cbus.arvalid && cbus.arready) begin
        cbus.rvalid <= 1'b1;
        cbus.rdata  <= mem[cbus.araddr[3:0]];
        cbus.rresp  <= rresp_val;
      end else if (cbus.rvalid && cbus.rready) begin
        cbus.rvalid <= 1'b0;
      end
    end
  end

  // Issue one command from a negedge in IDLE; lat counts cycles from the fire to rsp_valid.
  task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output int lat, output logic [31:0] rd, output logic [1:0] rs, output logic rw);
    int g;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    g = 0;
    while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    rd = rsp_rdata; rs = rsp_resp; rw = rsp_write;
    @(negedge clk);
  endtask

  int          lat, aw_cyc, w_cyc, addr_bad, early, stable, g, cnt, n_rsp;
  logic        aw_seen;
  logic [31:0] rd;
  logic [1:0]  rs;
  logic        rw;
  logic        got_w [8];
  logic [31:0] got_d [8];
  logic [1:0]  got_r [8];
  logic [31:0] exp_d [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_d[0] = 32'h0; exp_d[1] = 32'h0; exp_d[2] = 32'h0; exp_d[3] = 32'h0;
    exp_d[4] = 32'hFFFF_FFFF; exp_d[5] = 32'h0000_00FF;
    exp_d[6] = 32'h0000_FFFF; exp_d[7] = 32'h0000_0F0F;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_valids", 64'({cbus.awvalid, cbus.wvalid, cbus.arvalid, cbus.bready, cbus.rready, rsp_valid}), 64'(0));
    check("rst_payload", 64'({rsp_rdata, rsp_resp, rsp_write}), 64'(0));
    check("rst_addr", 64'({cbus.awaddr, cbus.wdata}), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Basic write then read with zero-wait slave
    run_cmd(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, lat, rd, rs, rw);
    check("wr_lat", 64'(lat), 64'(3));
    check("wr_resp", 64'({rw, rs, rd}), 64'({1'b1, 2'b00, 32'h0}));
    run_cmd(1'b0, 32'h4, 32'h0, 4'h0, lat, rd, rs, rw);
    check("rd_lat", 64'(lat), 64'(3));
    check("rd_resp", 64'({rw, rs, rd}), 64'({1'b0, 2'b00, 32'hDEAD_BEEF}));

    // AW stalled 5 cycles, W immediate
    aw_delay = 5;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'hAABB_CCDD; cmd_wstrb = 4'h3;
    @(negedge clk);
    cmd_valid = 1'b0;
    aw_cyc = 0; w_cyc = 0; addr_bad = 0; early = 0; aw_seen = 1'b0; lat = 1;
    while (!rsp_valid && lat < 30) begin
      if (cbus.bready && !aw_seen) early++;
      if (cbus.awvalid) begin
        aw_cyc++;
        if (cbus.awaddr != 32'h8) addr_bad++;
        if (cbus.awready) aw_seen = 1'b1;
      end
      if (cbus.wvalid) w_cyc++;
      @(negedge clk);
      lat++;
    end
    check("aw_stall_awvalid_cycles", 64'(aw_cyc), 64'(6));
    check("aw_stall_wvalid_cycles", 64'(w_cyc), 64'(1));
    check("aw_stall_addr_stable", 64'(addr_bad), 64'(0));
    check("aw_stall_bready_early", 64'(early), 64'(0));
    check("aw_stall_lat", 64'(lat), 64'(8));
    @(negedge clk);
    aw_delay = 0;
    run_cmd(1'b0, 32'h8, 32'h0, 4'h0, lat, rd, rs, rw);
    check("strobe_readback", 64'(rd), 64'(32'h0000_CCDD));

    // Response backpressure with a command waiting
    run_cmd(1'b1, 32'h0, 32'h1234_5678, 4'hF, lat, rd, rs, rw);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    g = 0;
    while (!rsp_valid && g < 20) begin @(negedge clk); g++; end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4;
    stable = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid && rsp_rdata == 32'h1234_5678 && rsp_resp == 2'b00 && !rsp_write && !cmd_ready) stable++;
      @(negedge clk);
    end
    check("bp_stable_cycles", 64'(stable), 64'(4));
    check("bp_still_valid", 64'({rsp_valid, cmd_ready}), 64'(2'b10));
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_released_idle", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
    @(negedge clk);
    check("bp_queued_accepted", 64'({cbus.arvalid, cmd_ready}), 64'(2'b10));
    cmd_valid = 1'b0;
    g = 0;
    while (!rsp_valid && g < 20) begin @(negedge clk); g++; end
    check("bp_queued_rdata", 64'(rsp_rdata), 64'(32'hDEAD_BEEF));
    @(negedge clk);

    // Error responses pass through
    bresp_val = 2'b10;
    run_cmd(1'b1, 32'hC, 32'h5A5A_5A5A, 4'hF, lat, rd, rs, rw);
    check("slverr_write", 64'({rw, rs}), 64'({1'b1, 2'b10}));
    bresp_val = 2'b00;
    rresp_val = 2'b11;
    run_cmd(1'b0, 32'hC, 32'h0, 4'h0, lat, rd, rs, rw);
    check("decerr_read", 64'({rw, rs, rd}), 64'({1'b0, 2'b11, 32'h5A5A_5A5A}));
    rresp_val = 2'b00;

    // Reset while waiting in WR_RESP
    b_hold = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    g = 0;
    while (!cbus.bready && g < 20) begin @(negedge clk); g++; end
    check("abort_reached_wr_resp", 64'(cbus.bready), 64'(1));
    rstn = 1'b0;
    #1;
    check("abort_outputs", 64'({cbus.awvalid, cbus.wvalid, cbus.bready, rsp_valid, cmd_ready}), 64'(5'b00001));
    @(negedge clk);
    rstn = 1'b1;
    b_hold = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("abort_no_rsp", 64'(cnt), 64'(0));
    run_cmd(1'b1, 32'h6, 32'h77, 4'hF, lat, rd, rs, rw);
    check("abort_next_write", 64'({lat[7:0], rw, rs}), 64'({8'd3, 1'b1, 2'b00}));

    // Back-to-back writes then reads, rsp_ready held high
    n_rsp = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          cmd_valid = 1'b1;
          cmd_write = (k < 4);
          cmd_addr  = 32'(k % 4);
          cmd_wdata = 32'hFFFF_FFFF;
          cmd_wstrb = 4'hF;
          g = 0;
          while (!cmd_ready && g < 20) begin @(negedge clk); g++; end
          @(negedge clk);
        end
        cmd_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (rsp_valid) begin
            if (n_rsp < 8) begin
              got_w[n_rsp] = rsp_write;
              got_d[n_rsp] = rsp_rdata;
              got_r[n_rsp] = rsp_resp;
            end
            n_rsp++;
          end
        end
      end
    join
    check("b2b_count", 64'(n_rsp), 64'(8));
    for (int k = 0; k < 8 && k < n_rsp; k++) begin
      check($sformatf("b2b_rsp%0d", k), 64'({got_w[k], got_r[k], got_d[k]}),
            64'({(k < 4) ? 1'b1 : 1'b0, 2'b00, exp_d[k]}));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
